// File: rtl/ifetch.sv
// Instruction fetch: PC register, combinational memory request, and a 2-entry {pc, inst} output FIFO.
// Optional JAL predecode follows the target directly when IFETCH_PREDECODE_EN is defined.
`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 10
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif

module ifetch #(
    parameter int          ADDR_W   = `MEMI_SIZE_LOG,
    parameter int          INST_W   = `INST_LEN,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] req_addr,
    input  logic [INST_W-1:0] resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc
);

    logic [ADDR_W-1:0] r_pc;
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_fpc   [2];
    logic [INST_W-1:0] r_finst [2];

    logic [ADDR_W-1:0] w_pc_nxt;
    logic [1:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] w_fpc_nxt   [2];
    logic [INST_W-1:0] w_finst_nxt [2];
    logic              w_deq;
    logic              w_enq;
    logic              w_slot;
    logic [ADDR_W-1:0] w_step;

`ifdef IFETCH_PREDECODE_EN
    logic [31:0] w_jimm;
    logic        w_is_jal;

    // J-type immediate is a byte offset; bits [ADDR_W+1:2] give the word step.
    always_comb begin
        w_jimm   = {{11{resp_data[31]}}, resp_data[31], resp_data[19:12],
                    resp_data[20], resp_data[30:21], 1'b0};
        w_is_jal = (resp_data[6:0] == 7'b1101111);
        w_step   = w_is_jal ? w_jimm[ADDR_W+1:2] : ADDR_W'(1);
    end
`else
    assign w_step = ADDR_W'(1);
`endif

    always_comb begin
        w_deq  = (r_cnt != 2'd0) && out_ready && !redirect_valid;
        w_enq  = !redirect_valid && ((r_cnt != 2'd2) || w_deq);
        // Entry index receiving the new fetch, after any same-edge pop.
        w_slot = (r_cnt == 2'd2) || ((r_cnt == 2'd1) && !w_deq);

        w_pc_nxt       = r_pc;
        w_cnt_nxt      = r_cnt;
        w_fpc_nxt[0]   = r_fpc[0];
        w_fpc_nxt[1]   = r_fpc[1];
        w_finst_nxt[0] = r_finst[0];
        w_finst_nxt[1] = r_finst[1];

        if (redirect_valid) begin
            w_pc_nxt  = redirect_pc;
            w_cnt_nxt = 2'd0;
        end else begin
            if (w_deq) begin
                w_fpc_nxt[0]   = r_fpc[1];
                w_finst_nxt[0] = r_finst[1];
            end
            if (w_enq) begin
                if (w_slot) begin
                    w_fpc_nxt[1]   = r_pc;
                    w_finst_nxt[1] = resp_data;
                end else begin
                    w_fpc_nxt[0]   = r_pc;
                    w_finst_nxt[0] = resp_data;
                end
                w_pc_nxt = r_pc + w_step;
            end
            w_cnt_nxt = r_cnt + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= ADDR_W'(RESET_PC);
            r_cnt      <= 2'd0;
            r_fpc[0]   <= '0;
            r_fpc[1]   <= '0;
            r_finst[0] <= '0;
            r_finst[1] <= '0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_fpc[0]   <= w_fpc_nxt[0];
            r_fpc[1]   <= w_fpc_nxt[1];
            r_finst[0] <= w_finst_nxt[0];
            r_finst[1] <= w_finst_nxt[1];
        end
    end

    assign req_addr  = r_pc;
    assign out_valid = (r_cnt != 2'd0);
    assign out_inst  = r_finst[0];
    assign out_pc    = r_fpc[0];

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios plus random traffic against a queue-based fetch model.
module tb_ifetch;
    localparam int AW = 3;
    localparam int IW = 32;
    localparam int MSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] req_addr;
    logic [IW-1:0] resp_data;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_inst;
    logic [AW-1:0] out_pc;

    logic [IW-1:0] mem [MSZ];

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
    } ent_t;

    ent_t          q[$];
    logic [AW-1:0] mpc;
    int            checks = 0;
    int            errors = 0;

    ifetch #(.ADDR_W(AW), .INST_W(IW), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .req_addr(req_addr), .resp_data(resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc)
    );

    always #5 clk = ~clk;
    assign resp_data = mem[req_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] next_pc(input logic [AW-1:0] pc, input logic [IW-1:0] inst);
        logic signed [31:0] off;
        off = 32'sd4;
`ifdef IFETCH_PREDECODE_EN
        if (inst[6:0] == 7'b1101111)
            off = $signed({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
`endif
        return AW'(int'(pc) + (off >>> 2));
    endfunction

    task automatic model_chk();
        chk("valid", 32'(out_valid), 32'(q.size() != 0));
        chk("req_addr", 32'(req_addr), 32'(mpc));
        if (q.size() != 0) begin
            chk("out_pc", 32'(out_pc), 32'(q[0].pc));
            chk("out_inst", out_inst, q[0].inst);
        end
    endtask

    // Check current state, apply inputs, advance the model, then clock.
    task automatic cyc(input logic rdy, input logic rv, input logic [AW-1:0] rp);
        ent_t e;
        model_chk();
        out_ready = rdy;
        redirect_valid = rv;
        redirect_pc = rp;
        if (rv) begin
            q.delete();
            mpc = rp;
        end else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (q.size() < 2) begin
                e.pc = mpc;
                e.inst = mem[mpc];
                q.push_back(e);
                mpc = next_pc(mpc, mem[mpc]);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        q.delete();
        mpc = '0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_pc"}, 32'(out_pc), 32'd0);
        chk({tag, "_inst"}, out_inst, 32'd0);
        chk({tag, "_req"}, 32'(req_addr), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MSZ; i++) mem[i] = 32'(i);
        mpc = '0;
        @(negedge clk);
        do_reset("rst0");

        // Streaming from reset: 0,1,2,... one cycle after release.
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, '0);
            chk("stream_pc", 32'(out_pc), 32'(i));
        end

        // Backpressure: saturates at two entries, then drains in order.
        do_reset("rst1");
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, '0);
        chk("stall_req", 32'(req_addr), 32'd2);
        chk("stall_pc", 32'(out_pc), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, '0);
            chk("drain_pc", 32'(out_pc), 32'(i + 1));
        end

        // Redirect while full: one bubble, then the target.
        do_reset("rst2");
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 3'd5);
        chk("redir_bubble", 32'(out_valid), 32'd0);
        chk("redir_req", 32'(req_addr), 32'd5);
        cyc(1'b1, 1'b0, '0);
        chk("redir_pc", 32'(out_pc), 32'd5);

        // Wrap at the top index: 7,0,1.
        cyc(1'b1, 1'b1, 3'd7);
        cyc(1'b1, 1'b0, '0);
        chk("wrap_pc0", 32'(out_pc), 32'd7);
        cyc(1'b1, 1'b0, '0);
        chk("wrap_pc1", 32'(out_pc), 32'd0);
        cyc(1'b1, 1'b0, '0);
        chk("wrap_pc2", 32'(out_pc), 32'd1);

        // JAL +8 bytes at index 0.
        mem[0] = 32'h0080006F;
        do_reset("rst3");
        cyc(1'b1, 1'b0, '0);
        chk("jal_pc0", 32'(out_pc), 32'd0);
        cyc(1'b1, 1'b0, '0);
        chk("jal_valid", 32'(out_valid), 32'd1);
`ifdef IFETCH_PREDECODE_EN
        chk("jal_pc1", 32'(out_pc), 32'd2);
`else
        chk("jal_pc1", 32'(out_pc), 32'd1);
`endif
        mem[0] = 32'd0;

        // Asynchronous reset mid-cycle with a full FIFO.
        do_reset("rst4");
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        chk("pre_async_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2;
        do_reset("async");
        cyc(1'b1, 1'b0, '0);
        chk("post_async_pc", 32'(out_pc), 32'd0);

        // Random traffic.
        for (int i = 0; i < MSZ; i++) mem[i] = $urandom;
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), AW'($urandom_range(0, MSZ - 1)));
        model_chk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
